// File: rtl/core_pkg.sv
// core_pkg: shared encodings, FSM states and MEM/WB record for the memory stage
package core_pkg;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
  } wb_t;
  // sz is funct3[1:0]: 00 byte, 01 half, anything else is a word access
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return sz == 2'b00 ? 1'b0 : sz == 2'b01 ? a[0] : |a;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: single-outstanding request/ready data-memory bus
interface mem_access_unit_if #(parameter int DW = 32);
  logic          mem_req, mem_we, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/load_extend.sv
// load_extend: byte/half lane select with sign or zero extension of a read word
module load_extend import core_pkg::*; (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
             funct3_i == F3_BU ? {24'h0, b} :
             funct3_i == F3_H  ? {{16{h[15]}}, h} :
             funct3_i == F3_HU ? {16'h0, h} : rdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage data-memory transaction FSM, stall/timeout and MEM/WB register
module mem_access_unit import core_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  mem_access_unit_if.master     bus,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  mem_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wdata_m, ext;
  logic [3:0]  wstrb_q, wstrb_d, wstrb_m;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d, store, load, mis, go, wt, req, stall, mis_o, berr;
  wb_t         wb_q, wb_d;
  assign store   = MemWriteM;
  assign load    = ResultSrcM == RES_MEM && !MemWriteM;
  assign mis     = (store | load) & misaligned(funct3M[1:0], ALUResultM[1:0]);
  assign go      = (store | load) & ~mis;
  assign wt      = state_q == WAIT;
  assign wdata_m = funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
                   funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
  assign wstrb_m = !store ? 4'b0000 :
                   funct3M[1:0] == 2'b00 ? 4'b0001 << ALUResultM[1:0] :
                   funct3M[1:0] == 2'b01 ? 4'b0011 << ALUResultM[1:0] : 4'b1111;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    req     = 1'b0;
    stall   = 1'b0;
    mis_o   = 1'b0;
    berr    = 1'b0;
    if (!wt) begin
      mis_o = mis;
      req   = go;
      stall = go & ~bus.mem_ready;
      if (stall) begin
        state_d = WAIT;
        cnt_d   = CW'(1);
        addr_d  = ALUResultM;
        we_d    = store;
        wdata_d = wdata_m;
        wstrb_d = wstrb_m;
        f3_d    = funct3M;
      end
    end else if (bus.mem_ready) begin
      req     = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
      berr    = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      req   = 1'b1;
      stall = 1'b1;
      cnt_d = cnt_q + CW'(1);
    end
  end
  // Combinational outputs are forced low while reset is held, even with a live M instruction
  assign bus.mem_req   = rst_n & req;
  assign bus.mem_we    = wt ? we_q : store;
  assign bus.mem_addr  = wt ? {addr_q[31:2], 2'b00} : {ALUResultM[31:2], 2'b00};
  assign bus.mem_wdata = wt ? wdata_q : wdata_m;
  assign bus.mem_wstrb = wt ? wstrb_q : wstrb_m;
  assign StallM        = rst_n & stall;
  assign MisalignM     = rst_n & mis_o;
  assign BusErrM       = berr;
  load_extend u_ext (
    .funct3_i(wt ? f3_q : funct3M),
    .off_i   (wt ? addr_q[1:0] : ALUResultM[1:0]),
    .rdata_i (bus.mem_rdata),
    .data_o  (ext)
  );
  always_comb begin
    wb_d    = wb_q;
    wb_d.rw = 1'b0;
    if (!stall) wb_d = '{RegWriteM & ~mis_o & ~berr, ResultSrcM, RdM, ALUResultM, ext, PCPlus4M};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      wb_q    <= wb_d;
    end
  end
  assign RegWriteW  = wb_q.rw;
  assign ResultSrcW = wb_q.rs;
  assign RdW        = wb_q.rd;
  assign ALUResultW = wb_q.alu;
  assign ReadDataW  = wb_q.rdat;
  assign PCPlus4W   = wb_q.pc4;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench driving M-stage instructions against a latency-programmable memory
module tb_mem_access_unit;
  import core_pkg::*;
  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        cd;
    logic [31:0] alu;
    logic        ca;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [1:0] ResultSrcM = 2'b00;
  logic [2:0] funct3M = 3'b000;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic [4:0] RdM = '0;
  logic StallM, MisalignM, BusErrM, RegWriteW;
  logic [1:0] ResultSrcW;
  logic [4:0] RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  int n_cmp = 0, n_bad = 0;
  exp_t sbq[$];
  mem_access_unit_if #(.DW(32)) bus ();
  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .bus(bus), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask
  task automatic issue(input string tag, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdt, input logic [4:0] rd, input int lat,
                       input logic [31:0] xdata, input logic [31:0] xwdata, input logic [3:0] xstrb,
                       input int xstall, input logic xmis, input logic xberr);
    exp_t e, g;
    int cyc, stalls;
    logic acc, xreq;
    acc  = mw | (rs == RES_MEM);
    xreq = acc & ~xmis;
    e.rw = rw & ~xmis & ~xberr;
    e.rd = rd;
    e.data = xdata;
    e.cd = (rs == RES_MEM) & ~mw & e.rw;
    e.alu = a;
    e.ca = xstall == 0;
    sbq.push_back(e);
    @(negedge clk);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = a; WriteDataM = wd; RdM = rd; PCPlus4M = a + 32'd4;
    bus.mem_ready = (lat == 0);
    bus.mem_rdata = rdt;
    #1;
    chk({tag, "_misalign"}, 32'(MisalignM), 32'(xmis));
    cyc = 0;
    stalls = 0;
    while (StallM && cyc < 40) begin
      stalls++;
      chk({tag, "_req_wait"}, 32'(bus.mem_req), 32'd1);
      chk({tag, "_addr_wait"}, bus.mem_addr, {a[31:2], 2'b00});
      chk({tag, "_wstrb_wait"}, 32'(bus.mem_wstrb), 32'(xstrb));
      if (mw) chk({tag, "_wdata_wait"}, bus.mem_wdata, xwdata);
      @(negedge clk);
      cyc++;
      ALUResultM = ~a;
      WriteDataM = ~wd;
      bus.mem_ready = (cyc == lat);
      #1;
      chk({tag, "_wb_bubble"}, 32'(RegWriteW), 32'd0);
    end
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(xstall));
    chk({tag, "_req"}, 32'(bus.mem_req), 32'(xreq & ~xberr));
    chk({tag, "_buserr"}, 32'(BusErrM), 32'(xberr));
    if (xreq && !xberr) begin
      chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
      chk({tag, "_we"}, 32'(bus.mem_we), 32'(mw));
      chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(xstrb));
      if (mw) chk({tag, "_wdata"}, bus.mem_wdata, xwdata);
    end
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    chk({tag, "_buserr_pulse"}, 32'(BusErrM), 32'd0);
    g = sbq.pop_front();
    chk({tag, "_RegWriteW"}, 32'(RegWriteW), 32'(g.rw));
    if (g.rw) chk({tag, "_RdW"}, 32'(RdW), 32'(g.rd));
    if (g.cd) chk({tag, "_ReadDataW"}, ReadDataW, g.data);
    if (g.ca && g.rw) chk({tag, "_ALUResultW"}, ALUResultW, g.alu);
  endtask
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #1;
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    //    tag     rw    rs       mw    f3     addr          wdata         rdata         rd  lat xdata         xwdata        strb     st mis berr
    issue("lw",   1'b1, RES_MEM, 1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 5'd5, 0, 32'hDEADBEEF, 32'h0,        4'b0000, 0, 1'b0, 1'b0);
    issue("lb",   1'b1, RES_MEM, 1'b0, F3_B,  32'h103, 32'h0,        32'h80AABBCC, 5'd6, 0, 32'hFFFFFF80, 32'h0,        4'b0000, 0, 1'b0, 1'b0);
    issue("lbu",  1'b1, RES_MEM, 1'b0, F3_BU, 32'h103, 32'h0,        32'h80AABBCC, 5'd7, 0, 32'h00000080, 32'h0,        4'b0000, 0, 1'b0, 1'b0);
    issue("lhu",  1'b1, RES_MEM, 1'b0, F3_HU, 32'h102, 32'h0,        32'h80AABBCC, 5'd8, 0, 32'h000080AA, 32'h0,        4'b0000, 0, 1'b0, 1'b0);
    issue("lh",   1'b1, RES_MEM, 1'b0, F3_H,  32'h102, 32'h0,        32'h80AABBCC, 5'd9, 0, 32'hFFFF80AA, 32'h0,        4'b0000, 0, 1'b0, 1'b0);
    issue("lb1",  1'b1, RES_MEM, 1'b0, F3_B,  32'h101, 32'h0,        32'h11227F44, 5'd10, 0, 32'h0000007F, 32'h0,       4'b0000, 0, 1'b0, 1'b0);
    issue("sh",   1'b0, RES_ALU, 1'b1, F3_H,  32'h206, 32'h1234ABCD, 32'h0,        5'd0, 2, 32'h0,        32'hABCDABCD, 4'b1100, 2, 1'b0, 1'b0);
    issue("sb",   1'b0, RES_ALU, 1'b1, F3_B,  32'h201, 32'h000000EF, 32'h0,        5'd0, 1, 32'h0,        32'hEFEFEFEF, 4'b0010, 1, 1'b0, 1'b0);
    issue("sw",   1'b0, RES_ALU, 1'b1, F3_W,  32'h300, 32'hCAFEF00D, 32'h0,        5'd0, 0, 32'h0,        32'hCAFEF00D, 4'b1111, 0, 1'b0, 1'b0);
    issue("lwslow", 1'b1, RES_MEM, 1'b0, F3_W, 32'h104, 32'h0,       32'h01020304, 5'd11, 3, 32'h01020304, 32'h0,       4'b0000, 3, 1'b0, 1'b0);
    issue("lbslow", 1'b1, RES_MEM, 1'b0, F3_B, 32'h102, 32'h0,       32'h00F00000, 5'd12, 2, 32'hFFFFFFF0, 32'h0,       4'b0000, 2, 1'b0, 1'b0);
    issue("lwmis", 1'b1, RES_MEM, 1'b0, F3_W, 32'h102, 32'h0,        32'h0,        5'd13, 0, 32'h0,       32'h0,        4'b0000, 0, 1'b1, 1'b0);
    issue("shmis", 1'b0, RES_ALU, 1'b1, F3_H, 32'h205, 32'h0,        32'h0,        5'd0, 0, 32'h0,        32'h0,        4'b0000, 0, 1'b1, 1'b0);
    issue("tmo",  1'b1, RES_MEM, 1'b0, F3_W,  32'h400, 32'h0,        32'h0,        5'd14, 100, 32'h0,     32'h0,        4'b0000, 16, 1'b0, 1'b1);
    issue("alu",  1'b1, RES_ALU, 1'b0, F3_W,  32'h12345678, 32'h0,   32'h0,        5'd7, 0, 32'h0,        32'h0,        4'b0000, 0, 1'b0, 1'b0);
    issue("pc4",  1'b1, RES_PC4, 1'b0, F3_B,  32'h00000042, 32'h0,   32'h0,        5'd3, 0, 32'h0,        32'h0,        4'b0000, 0, 1'b0, 1'b0);
    chk("pc4_PCPlus4W", PCPlus4W, 32'h00000046);
    @(negedge clk);
    RegWriteM = 1'b1; ResultSrcM = RES_MEM; MemWriteM = 1'b0; funct3M = F3_W;
    ALUResultM = 32'h500; RdM = 5'd20;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstw_stall_before", 32'(StallM), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_req", 32'(bus.mem_req), 32'd0);
    chk("rstw_StallM", 32'(StallM), 32'd0);
    chk("rstw_RdW", 32'(RdW), 32'd0);
    chk("rstw_ALUResultW", ALUResultW, 32'd0);
    chk("rstw_PCPlus4W", PCPlus4W, 32'd0);
    chk("rstw_BusErrM", 32'(BusErrM), 32'd0);
    @(negedge clk);
    RegWriteM = 1'b0; ResultSrcM = RES_ALU;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    chk("rstw_no_wb", 32'(RegWriteW), 32'd0);
    chk("rstw_idle_stall", 32'(StallM), 32'd0);
    chk("rstw_idle_req", 32'(bus.mem_req), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
